// File: rtl/bram_tile_ctrl.sv
// rtl/bram_tile_ctrl.sv - tile sequencer: narrow stream into BRAM port A, wide words out of port B
module bram_tile_ctrl #(
  parameter int A_WIDTH         = 32,
  parameter int B_WIDTH         = 64,
  parameter int A_ADDRESS_WIDTH = 2,
  parameter int B_ADDRESS_WIDTH = 1,
  parameter int TILE_A_WORDS    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_WIDTH-1:0]         in_data,
  output logic                       bram_ena,
  output logic                       bram_wea,
  output logic [A_ADDRESS_WIDTH-1:0] bram_addra,
  output logic [A_WIDTH-1:0]         bram_dina,
  output logic                       bram_enb,
  output logic                       bram_web,
  output logic [B_ADDRESS_WIDTH-1:0] bram_addrb,
  input  logic [B_WIDTH-1:0]         bram_doutb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [B_WIDTH-1:0]         out_data
);

  localparam int RATIO        = B_WIDTH / A_WIDTH;
  localparam int TILE_B_WORDS = TILE_A_WORDS / RATIO;

  localparam logic [A_ADDRESS_WIDTH-1:0] WR_LAST = A_ADDRESS_WIDTH'(TILE_A_WORDS - 1);
  localparam logic [B_ADDRESS_WIDTH-1:0] RD_LAST = B_ADDRESS_WIDTH'(TILE_B_WORDS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_RD_ADDR = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]                 state;
  logic [A_ADDRESS_WIDTH-1:0] wr_cnt;
  logic [B_ADDRESS_WIDTH-1:0] rd_cnt;
  logic                       wr_fire;
  logic                       rd_fire;

  // out_valid is always high while in OUT, so the downstream handshake is just out_ready there
  assign wr_fire = (state == S_LOAD) && in_valid;
  assign rd_fire = (state == S_OUT) && out_ready;

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_LOAD);

  // Port A writes straight through on the upstream handshake; addresses are parked at 0 otherwise
  assign bram_ena   = wr_fire;
  assign bram_wea   = wr_fire;
  assign bram_addra = wr_fire ? wr_cnt : '0;
  assign bram_dina  = wr_fire ? in_data : '0;

  // Port B is read-only and issues exactly one read per wide word
  assign bram_enb   = (state == S_RD_ADDR);
  assign bram_web   = 1'b0;
  assign bram_addrb = (state == S_RD_ADDR) ? rd_cnt : '0;

  // Tile sequencing FSM with registered output stream and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD;
            wr_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            if (wr_cnt == WR_LAST) begin
              state  <= S_RD_ADDR;
              wr_cnt <= '0;
              rd_cnt <= '0;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        S_RD_ADDR: begin
          state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          out_data  <= bram_doutb;
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (rd_fire) begin
            out_valid <= 1'b0;
            if (rd_cnt == RD_LAST) begin
              rd_cnt <= '0;
              done   <= 1'b1;
              state  <= S_DONE;
            end else begin
              rd_cnt <= rd_cnt + 1'b1;
              state  <= S_RD_ADDR;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_tile_ctrl.sv
// tb/tb_bram_tile_ctrl.sv - directed and randomized bench for bram_tile_ctrl with an asymmetric BRAM model
module tb_bram_tile_ctrl;

  localparam int AW  = 32;
  localparam int BW  = 64;
  localparam int AAW = 2;
  localparam int BAW = 1;
  localparam int TA  = 4;
  localparam int R   = BW / AW;
  localparam int TBW = TA / R;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           busy;
  logic           done;
  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  in_data;
  logic           bram_ena;
  logic           bram_wea;
  logic [AAW-1:0] bram_addra;
  logic [AW-1:0]  bram_dina;
  logic           bram_enb;
  logic           bram_web;
  logic [BAW-1:0] bram_addrb;
  logic [BW-1:0]  bram_doutb;
  logic           out_valid;
  logic           out_ready;
  logic [BW-1:0]  out_data;

  bram_tile_ctrl #(
    .A_WIDTH(AW), .B_WIDTH(BW), .A_ADDRESS_WIDTH(AAW), .B_ADDRESS_WIDTH(BAW), .TILE_A_WORDS(TA)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
    .bram_enb(bram_enb), .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Asymmetric BRAM: narrow write port, wide registered read port, low narrow word in the LSBs
  logic [AW-1:0] mem [TA];
  always @(posedge clk) begin
    if (bram_ena && bram_wea) mem[bram_addra] <= bram_dina;
    if (bram_enb) begin
      for (int j = 0; j < R; j++) bram_doutb[j*AW +: AW] <= mem[int'(bram_addrb) * R + j];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW-1:0] tile [TA];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] packed_word(input int k);
    logic [BW-1:0] w;
    w = '0;
    for (int j = 0; j < R; j++) w[j*AW +: AW] = tile[k*R + j];
    return w;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    next();
    start = 1'b0;
  endtask

  task automatic load_tile(input bit gaps, input bit poke, input int nwords, output int e0);
    for (int i = 0; i < nwords; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          @(negedge clk);
          check("gap_no_write", {in_ready, bram_ena, bram_wea}, 3'b100);
          next();
        end
      end
      in_valid = 1'b1;
      in_data  = tile[i];
      start    = poke && (i == 1);
      @(negedge clk);
      check("wr_en", {in_ready, bram_ena, bram_wea}, 3'b111);
      check("wr_addr", 64'(bram_addra), 64'(i));
      check("wr_data", 64'(bram_dina), 64'(tile[i]));
      next();
      start = 1'b0;
    end
    in_valid = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else next();
    end
  endtask

  task automatic recv_word(input int k, input int ref_cyc, input int exp_delay, input int hold,
                           input bit poke, output int rise, output int hs);
    bit seen;
    logic [BW-1:0] held;
    wait_valid(seen);
    check("out_valid_seen", 64'(seen), 64'd1);
    rise = cyc;
    if (exp_delay > 0) check("out_latency", 64'(rise - ref_cyc), 64'(exp_delay));
    check("out_data", out_data, packed_word(k));
    check("in_ready_low_out", 64'(in_ready), 64'd0);
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      start = poke && (h == 1);
      next();
      start = 1'b0;
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", out_data, held);
      check("bp_no_enb", 64'(bram_enb), 64'd0);
    end
    out_ready = 1'b1;
    next();
    hs = cyc;
  endtask

  task automatic run_tile(input bit rnd, input bit gaps, input bit poke, input int hold_word,
                          input bit start_in_done);
    int e0, rise, prev_rise, hs, d0, dly;
    if (rnd) for (int i = 0; i < TA; i++) tile[i] = $urandom;
    d0 = done_cnt;
    out_ready = 1'b1;
    do_start();
    @(negedge clk);
    check("busy_load", {busy, in_ready}, 2'b11);
    next();
    load_tile(gaps, poke, TA, e0);
    prev_rise = e0;
    for (int k = 0; k < TBW; k++) begin
      if (k == 0) dly = 2;
      else if (k - 1 == hold_word) dly = 0;
      else dly = 3;
      if (k == hold_word) out_ready = 1'b0;
      recv_word(k, prev_rise, dly, (k == hold_word) ? 5 : 0, poke, rise, hs);
      prev_rise = rise;
    end
    start = start_in_done;
    @(negedge clk);
    check("done_pulse", {done, busy}, 2'b11);
    next();
    start = 1'b0;
    @(negedge clk);
    check("done_clear", {done, busy}, 2'b00);
    next();
    @(negedge clk);
    check("stay_idle", 64'(busy), 64'd0);
    check("done_count", 64'(done_cnt - d0), 64'd1);
    next();
  endtask

  initial begin
    int e0;
    bit seen;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy_done", {busy, done, in_ready, out_valid}, 4'b0000);
    check("rst_out_data", out_data, 64'd0);
    check("rst_port_a", {bram_ena, bram_wea, 2'(bram_addra)}, 4'b0000);
    check("rst_port_b", {bram_enb, bram_web, 1'(bram_addrb)}, 3'b000);
    rst = 1'b0;
    next();

    tile[0] = 32'h11111111; tile[1] = 32'h22222222; tile[2] = 32'h33333333; tile[3] = 32'h44444444;
    run_tile(1'b0, 1'b0, 1'b0, -1, 1'b0);
    check("basic_last_word", out_data, 64'h4444444433333333);

    run_tile(1'b0, 1'b1, 1'b0, -1, 1'b0);
    run_tile(1'b1, 1'b0, 1'b1, 0, 1'b1);
    run_tile(1'b1, 1'b1, 1'b0, 1, 1'b0);

    // Reset after two words have been loaded
    for (int i = 0; i < TA; i++) tile[i] = $urandom;
    do_start();
    load_tile(1'b0, 1'b0, 2, e0);
    #2 rst = 1'b1;
    #1;
    check("rst_load_idle", {busy, in_ready, out_valid, bram_ena}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    next();
    run_tile(1'b1, 1'b1, 1'b0, -1, 1'b0);

    // Reset while a wide word is being presented
    for (int i = 0; i < TA; i++) tile[i] = $urandom;
    do_start();
    load_tile(1'b0, 1'b0, TA, e0);
    out_ready = 1'b0;
    wait_valid(seen);
    check("pre_rst_valid", 64'(seen), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_out_idle", {busy, out_valid, bram_enb}, 3'b000);
    check("rst_out_data_clr", out_data, 64'd0);
    #2 rst = 1'b0;
    next();
    run_tile(1'b1, 1'b0, 1'b0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
